mode_counter: RTL
=================

// Module: mode_counter
// PURPOSE
//   Parametrised multi-mode counter. It generalises the demo's fixed 8-bit free-running
//   counter in four ways: configurable width, an enable-qualified prescaler, synchronous
//   load, and four count modes with a terminal-count pulse.
//   Sits between the tt_um_* top and its pin muxing: top drives mode/load from ui_in/uio_in,
//   and routes count/tc/done to uo_out/uio_out.
// PARAMETERS
//   WIDTH       8   counter width in bits (>=2)
//   PRESCALE_W  4   prescaler compare width; step every (prescale+1) enabled cycles
// PORTS
//   clk       in   1            single clock, all logic on rising edge
//   rst       in   1            synchronous reset, active-high
//   en        in   1            count enable; low freezes prescaler and count
//   mode      in   2            00 up-wrap, 01 down-wrap, 10 up-saturate, 11 one-shot down
//   prescale  in   PRESCALE_W   step divider; 0 = step every enabled cycle
//   load      in   1            synchronous load strobe
//   load_val  in   WIDTH        value taken on load
//   count     out  WIDTH        current count (registered)
//   tc        out  1            terminal-count pulse, one cycle, registered
//   done      out  1            high while in HALT (modes 10/11 only)
// BEHAVIOUR
//   Reset (rst=1 at edge): count=0, tc=0, done=0, prescaler pcnt=0, state=RUN.
//   Priority each edge: rst > load > step.
//   Load: count<=load_val; pcnt<=0; tc<=0. State RUN, except: mode 10 with load_val=MAX,
//     or mode 11 with load_val=0 -> state HALT, done=1, no tc pulse.
//   Prescaler: in RUN with en=1 and no load, pcnt==prescale -> step, pcnt<=0; else pcnt+1.
//     en=0: pcnt and count hold; tc<=0. Prescale change takes effect at next compare.
//     If prescale is lowered below pcnt, pcnt counts on, wraps through 2^PRESCALE_W-1 to 0, then compares.
//   Step (MAX = 2^WIDTH-1, all arithmetic modulo 2^WIDTH):
//     00: count+1; MAX->0 sets tc for that cycle.
//     01: count-1; 0->MAX sets tc.
//     10: count+1; reaching MAX sets tc, state->HALT.
//     11: count-1; reaching 0 sets tc, state->HALT.
//   tc is high exactly in the cycle count first shows the post-event value; otherwise tc=0.
//   Latency: step visible on count one edge after the compare cycle; load visible next cycle.
//   HALT: count, pcnt frozen; done=1; tc=0. Exits only on load or rst.
//     Mode changes are ignored in HALT.
//   Mode change in RUN applies to the next step; no tc is generated by the change itself.
//     Example: mode 10 -> 00 at MAX in RUN wraps next step with tc.
//   Mode 00/01 never enter HALT; done=0 whenever state=RUN.
//   Simultaneous load and step-condition: load wins, no step, no tc.
//   rst mid-HALT or mid-prescale: full reset values next cycle.
// TESTING
//   T1 WIDTH=8, mode 00, prescale 0, en=1 from reset:
//      count 0,1,..,255,0; tc=1 only on the cycle count=0 after 255.
//   T2 mode 01, load 8'h02, prescale 2:
//      count 2 held 3 cycles, then 1, 0, then 255 with tc=1; a step every 3 cycles.
//   T3 mode 10, load 8'hFD: count FE, FF (tc=1, done=1), then holds FF;
//      tc=0 after that; mode->00 keeps FF held.
//   T4 mode 11, load 8'h03: count 2, 1, 0 (tc=1), done=1.
//      load 8'h00 -> done=1, no tc; load 8'h05 -> done=0, counts again.
//   T5 en toggled 0 mid-prescale (prescale 3, pcnt=2): count and pcnt hold.
//      On re-enable, step after 1 more enabled cycle.
//   T6 load and step-condition same edge: count=load_val, tc=0.
//      rst asserted during HALT -> count=0, done=0, tc=0 next cycle.

Source files
------------

// File: rtl/mode_counter.sv
// Multi-mode counter: up/down wrap, up-saturate and one-shot down, with an enable-gated
// prescaler, synchronous load and a registered one-cycle terminal-count pulse.
module mode_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done
);

    typedef enum logic {
        StRun,
        StHalt
    } state_e;

    localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZeroVal = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] OneVal = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] POne = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
    logic                    tc_q, tc_d;
    logic                    done_q, done_d;

    logic [WIDTH-1:0]        count_inc;
    logic [WIDTH-1:0]        count_dec;
    logic                    step;
    logic                    load_halts;

    assign count_inc = count_q + OneVal;
    assign count_dec = count_q - OneVal;
    assign step      = (state_q == StRun) && en && (pcnt_q == prescale);

    // A load that already sits at the saturating mode's terminal value parks immediately.
    assign load_halts = ((mode == 2'b10) && (load_val == MaxVal)) ||
                        ((mode == 2'b11) && (load_val == ZeroVal));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pcnt_d  = pcnt_q;
        tc_d    = 1'b0;

        if (load) begin
            count_d = load_val;
            pcnt_d  = '0;
            state_d = load_halts ? StHalt : StRun;
        end else if (step) begin
            pcnt_d = '0;
            unique case (mode)
                2'b00: begin
                    count_d = count_inc;
                    tc_d    = (count_q == MaxVal);
                end
                2'b01: begin
                    count_d = count_dec;
                    tc_d    = (count_q == ZeroVal);
                end
                2'b10: begin
                    count_d = count_inc;
                    if (count_inc == MaxVal) begin
                        tc_d    = 1'b1;
                        state_d = StHalt;
                    end
                end
                2'b11: begin
                    count_d = count_dec;
                    if (count_dec == ZeroVal) begin
                        tc_d    = 1'b1;
                        state_d = StHalt;
                    end
                end
                default: ;
            endcase
        end else if ((state_q == StRun) && en) begin
            // Lowering prescale below pcnt lets pcnt run on and wrap before matching.
            pcnt_d = pcnt_q + POne;
        end

        done_d = (state_d == StHalt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            count_q <= '0;
            pcnt_q  <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule
